// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared instruction-memory geometry and the boot-loader state encoding used by
// imem_loader, its word assembler and its bus interface.
// No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package mips_mem_pkg;

  localparam int IMEM_ADDR_W = 11;
  localparam int IMEM_DEPTH  = 1024;
  localparam int IMEM_WORD_W = 32;

  // LD_ZERO is only reachable when the zero-fill tail is compiled in.
  typedef enum logic [2:0] {
    LD_HDR0  = 3'd0,
    LD_HDR1  = 3'd1,
    LD_DATA  = 3'd2,
    LD_WRITE = 3'd3,
    LD_ZERO  = 3'd4,
    LD_DONE  = 3'd5,
    LD_RUN   = 3'd6,
    LD_ERR   = 3'd7
  } ldr_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Groups the boot byte stream and the shared imem address/write port.
//   rx_data/rx_valid/rx_ready : byte stream, transfer on rx_valid && rx_ready
//   cpu_addr                  : CPU fetch word address
//   imem_a/imem_we/imem_wd    : imem address, write strobe, write data
// Modports:
//   master : the loader (drives rx_ready and the imem port)
//   slave  : the environment (byte source, CPU fetch, memory)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface imem_loader_if #(
  parameter int ADDR_W = mips_mem_pkg::IMEM_ADDR_W
);
  logic [7:0]                            rx_data;
  logic                                  rx_valid;
  logic                                  rx_ready;
  logic [ADDR_W-1:0]                     cpu_addr;
  logic [ADDR_W-1:0]                     imem_a;
  logic                                  imem_we;
  logic [mips_mem_pkg::IMEM_WORD_W-1:0]  imem_wd;

  modport master (
    input  rx_data, rx_valid, cpu_addr,
    output rx_ready, imem_a, imem_we, imem_wd
  );

  modport slave (
    output rx_data, rx_valid, cpu_addr,
    input  rx_ready, imem_a, imem_we, imem_wd
  );
endinterface

// File: rtl/imem_loader_word_asm.sv
// -----------------------------------------------------------------------------
// imem_loader_word_asm
// Assembles big-endian 32-bit words from a byte stream (first byte lands in
// the MSB) and flags the cycle on which the fourth byte is shifted in.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset (byte counter only)
//   i_shift       : accept i_byte this cycle
//   i_byte        : incoming byte
//   o_word        : assembled word (complete on the cycle after o_word_done)
//   o_word_done   : combinational, high while the fourth byte is accepted
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module imem_loader_word_asm
  import mips_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_shift,
  input  logic [7:0]             i_byte,
  output logic [IMEM_WORD_W-1:0] o_word,
  output logic                   o_word_done
);

  logic [1:0]             r_byte_idx;
  logic [IMEM_WORD_W-1:0] r_word;

  // Two-bit index wraps from 3 back to 0 on the word-completing byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_idx <= 2'd0;
    end else if (i_shift) begin
      r_byte_idx <= r_byte_idx + 2'd1;
    end
  end

  // Data path only; its contents are meaningless until four bytes arrive.
  always_ff @(posedge clk) begin
    if (i_shift) begin
      r_word <= {r_word[IMEM_WORD_W-9:0], i_byte};
    end
  end

  assign o_word      = r_word;
  assign o_word_done = i_shift && (r_byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Shares the single-port instruction memory between the CPU fetch path and a
// byte-stream boot loader. A load is a 16-bit big-endian word count followed
// by that many big-endian 32-bit words, written from address 0 upward while
// the CPU is held in reset. On completion the CPU is released and imem_a
// follows cpu_addr again.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (boots into a load)
//   load_start   : request a new load, honoured in RUN or ERR only
//   bus          : imem_loader_if.master (byte stream, cpu_addr, imem port)
//   cpu_reset    : active-high reset to the core, low only in RUN
//   load_busy    : high in every state except RUN and ERR
//   load_done    : one-cycle pulse when a load completes
//   load_err     : sticky word-count overflow flag
// Build option:
//   IMEM_LOADER_ZERO_FILL_EN : after the last word, write zero to every
//   remaining address up to DEPTH-1 before releasing the CPU.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module imem_loader
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_start,
  imem_loader_if.master bus,
  output logic          cpu_reset,
  output logic          load_busy,
  output logic          load_done,
  output logic          load_err
);

  localparam int          PAD       = 16 - (ADDR_W + 1);
  localparam logic [15:0] L_DEPTH16 = 16'(DEPTH);
`ifdef IMEM_LOADER_ZERO_FILL_EN
  localparam logic [ADDR_W:0] L_DEPTHP  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] L_LAST    = (ADDR_W+1)'(DEPTH - 1);
  localparam ldr_state_t      L_TAIL_ST = LD_ZERO;
`else
  localparam ldr_state_t      L_TAIL_ST = LD_DONE;
`endif

  ldr_state_t             r_state, w_state_nxt;
  // One bit wider than the address so a count of DEPTH compares without wrap.
  logic [ADDR_W:0]        r_ptr, w_ptr_nxt, w_ptr_inc;
  logic [15:0]            r_cnt, w_cnt_nxt, w_hdr_cnt;
  logic                   r_err, w_err_nxt;
  logic                   w_rx_ready, w_xfer, w_shift, w_word_done, w_ptr_hit;
  logic [IMEM_WORD_W-1:0] w_word;

  assign w_rx_ready = (r_state == LD_HDR0) || (r_state == LD_HDR1) ||
                      (r_state == LD_DATA);
  assign w_xfer     = bus.rx_valid && w_rx_ready;
  assign w_shift    = w_xfer && (r_state == LD_DATA);
  assign w_hdr_cnt  = {r_cnt[15:8], bus.rx_data};
  assign w_ptr_inc  = r_ptr + 1'b1;
  assign w_ptr_hit  = ({{PAD{1'b0}}, w_ptr_inc} == r_cnt);

  imem_loader_word_asm u_word_asm (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_shift     (w_shift),
    .i_byte      (bus.rx_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= LD_HDR0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      LD_HDR0: begin
        if (w_xfer) begin
          w_cnt_nxt[15:8] = bus.rx_data;
          w_state_nxt     = LD_HDR1;
        end
      end
      LD_HDR1: begin
        if (w_xfer) begin
          w_cnt_nxt = w_hdr_cnt;
          if (w_hdr_cnt > L_DEPTH16) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = LD_ERR;
          end else if (w_hdr_cnt == 16'd0) begin
            w_state_nxt = L_TAIL_ST;
          end else begin
            w_state_nxt = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (w_word_done) w_state_nxt = LD_WRITE;
      end
      LD_WRITE: begin
        w_ptr_nxt = w_ptr_inc;
        if (w_ptr_hit) begin
`ifdef IMEM_LOADER_ZERO_FILL_EN
          // A full-depth image has nothing left to clear.
          w_state_nxt = (w_ptr_inc < L_DEPTHP) ? LD_ZERO : LD_DONE;
`else
          w_state_nxt = LD_DONE;
`endif
        end else begin
          w_state_nxt = LD_DATA;
        end
      end
`ifdef IMEM_LOADER_ZERO_FILL_EN
      LD_ZERO: begin
        w_ptr_nxt = w_ptr_inc;
        if (r_ptr == L_LAST) w_state_nxt = LD_DONE;
      end
`endif
      LD_DONE: begin
        w_state_nxt = LD_RUN;
      end
      LD_RUN: begin
        if (load_start) begin
          w_ptr_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = LD_HDR0;
        end
      end
      LD_ERR: begin
        if (load_start) begin
          w_err_nxt   = 1'b0;
          w_ptr_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = LD_HDR0;
        end
      end
      default: w_state_nxt = LD_HDR0;
    endcase
  end

  // Everything except imem_a is a pure decode of registered state.
  assign bus.rx_ready = w_rx_ready;
  assign bus.imem_we  = (r_state == LD_WRITE) || (r_state == LD_ZERO);
  assign bus.imem_wd  = (r_state == LD_WRITE) ? w_word : '0;
  assign bus.imem_a   = (r_state == LD_RUN) ? bus.cpu_addr : r_ptr[ADDR_W-1:0];
  assign cpu_reset    = (r_state != LD_RUN);
  assign load_busy    = (r_state != LD_RUN) && (r_state != LD_ERR);
  assign load_done    = (r_state == LD_DONE);
  assign load_err     = r_err;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
  import mips_mem_pkg::*;

  localparam int DEPTH  = IMEM_DEPTH;
  localparam int ADDR_W = IMEM_ADDR_W;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic load_start = 1'b0;
  logic cpu_reset, load_busy, load_done, load_err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_start (load_start),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  logic [31:0] tb_mem [DEPTH];
  logic [31:0] obs_a[$];
  logic [31:0] obs_d[$];
  logic [31:0] img[$];
  bit          rnd_valid = 0;
  bit          mid_start = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model plus write log; every write must happen with rx_ready low.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      obs_a.push_back(32'(bus.imem_a));
      obs_d.push_back(bus.imem_wd);
      if (32'(bus.imem_a) < DEPTH) tb_mem[bus.imem_a] = bus.imem_wd;
      chk("rx_ready_during_write", 32'(bus.rx_ready), 32'd0);
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    int guard;
    bit took;
    guard = 0;
    took  = 0;
    if (rnd_valid) begin
      while ($urandom_range(1, 0) == 1 && guard < 20) begin
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
        guard++;
      end
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    guard = 0;
    while (!took && guard < 200) begin
      @(negedge clk);
      took = bus.rx_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!took) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  // Header carries img.size(); only the first nwords words are streamed.
  task automatic send_image(input int nwords);
    logic [15:0] n;
    n = 16'(img.size());
    obs_a.delete();
    obs_d.delete();
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    if (mid_start) begin
      bus.rx_valid = 1'b0;
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      chk("mid_start_ignored_busy", 32'(load_busy), 32'd1);
      chk("mid_start_ignored_rst", 32'(cpu_reset), 32'd1);
    end
    for (int i = 0; i < nwords; i++) begin
      logic [31:0] w;
      w = img[i];
      for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_writes();
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    for (int i = 0; i < img.size(); i++) begin
      ea.push_back(32'(i));
      ed.push_back(img[i]);
    end
`ifdef IMEM_LOADER_ZERO_FILL_EN
    for (int a = img.size(); a < DEPTH; a++) begin
      ea.push_back(32'(a));
      ed.push_back(32'd0);
    end
`endif
    chk("write_count", 32'(obs_a.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < obs_a.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), obs_a[i], ea[i]);
      chk($sformatf("wr_data[%0d]", i), obs_d[i], ed[i]);
    end
  endtask

  task automatic wait_done();
    int  n;
    int  d0;
    bit  seen;
    n = 0;
    seen = 0;
    d0 = done_cnt;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (load_done === 1'b1) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("cpu_reset_held_in_done", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    chk("cpu_reset_released", 32'(cpu_reset), 32'd0);
    chk("busy_low_in_run", 32'(load_busy), 32'd0);
    chk("done_single_pulse", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk("start_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("start_busy", 32'(load_busy), 32'd1);
    chk("start_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("start_err_clear", 32'(load_err), 32'd0);
  endtask

  task automatic check_run_mux();
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom_range(2047, 0));
    bus.cpu_addr = a;
    #1;
    chk("imem_a_follows_cpu", 32'(bus.imem_a), 32'(a));
    chk("no_we_in_run", 32'(bus.imem_we), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    chk({tag, "_imem_wd"}, bus.imem_wd, 32'd0);
    chk({tag, "_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_load_err"}, 32'(load_err), 32'd0);
    chk({tag, "_busy"}, 32'(load_busy), 32'd1);
    chk({tag, "_imem_a_ptr0"}, 32'(bus.imem_a), 32'd0);
  endtask

  initial begin
    int g;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.cpu_addr = '0;
    #1 reset_n = 1'b0;
    #11;
    check_reset_outputs("por");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Boot image straight out of reset.
    img = '{32'h20080005, 32'hAC08003C};
    send_image(2);
    wait_done();
    check_writes();
    bus.cpu_addr = 11'h012;
    #1;
    chk("imem_a_cpu_012", 32'(bus.imem_a), 32'h012);

    // Same image with a bursty byte source.
    start_load();
    rnd_valid = 1;
    send_image(2);
    wait_done();
    check_writes();
    check_run_mux();
    rnd_valid = 0;

    // Oversized header: error, no writes, recovery via load_start.
    start_load();
    obs_a.delete();
    obs_d.delete();
    send_byte(8'h04);
    send_byte(8'h01);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    chk("err_flag", 32'(load_err), 32'd1);
    chk("err_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("err_busy", 32'(load_busy), 32'd0);
    chk("err_rx_ready", 32'(bus.rx_ready), 32'd0);
    bus.rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("err_no_writes", 32'(obs_a.size()), 32'd0);
    chk("err_sticky", 32'(load_err), 32'd1);
    start_load();
    img = '{$urandom(), $urandom()};
    send_image(2);
    wait_done();
    check_writes();

    // Reload from RUN, with a load_start mid-stream that must be ignored.
    start_load();
    img = '{32'h12345678};
    mid_start = 1;
    send_image(1);
    mid_start = 0;
    wait_done();
    check_writes();
    check_run_mux();

    // Asynchronous reset after two of three words.
    start_load();
    img = '{32'hA5A50001, 32'h5A5A0002, 32'hC3C30003};
    send_image(2);
    g = 0;
    while (obs_a.size() < 2 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("two_words_before_reset", 32'(obs_a.size()), 32'd2);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    chk("retained_word0", tb_mem[0], 32'hA5A50001);
    chk("retained_word1", tb_mem[1], 32'h5A5A0002);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("no_write_after_reset", 32'(obs_a.size()), 32'd2);

    // Exactly DEPTH words is legal (boot load after the reset above).
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom());
    send_image(DEPTH);
    wait_done();
    check_writes();
    chk("full_depth_no_err", 32'(load_err), 32'd0);

    // Empty image.
    start_load();
    img.delete();
    send_image(0);
    wait_done();
    check_writes();

    // Randomized images and byte-valid patterns.
    for (int t = 0; t < 6; t++) begin
      int n;
      start_load();
      n = $urandom_range(8, 1);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom());
      rnd_valid = bit'($urandom_range(1, 0));
      send_image(n);
      wait_done();
      check_writes();
      check_run_mux();
    end
    rnd_valid = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Sequences and shares the single-port instruction memory between the CPU fetch path and a byte-stream boot loader. The byte stream comes from the UART/debug link.
- During a load it holds the CPU in reset and owns the imem address/write port. It assembles big-endian 32-bit words and writes them from address 0 upward.
- When the load completes it releases the CPU, and imem address ownership returns to the fetch path.

Parameters:
- ADDR_W, 11, imem word-address width.
- DEPTH, 1024, number of imem words; a load of more than DEPTH words is an error.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle request to begin a new load; honoured only in RUN or ERR.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte; a byte transfers when rx_valid && rx_ready.
- cpu_addr  in  ADDR_W  CPU fetch word address.
- imem_a  out  ADDR_W  imem address: cpu_addr in RUN, loader pointer otherwise.
- imem_we  out  1  imem write strobe.
- imem_wd  out  32  imem write data.
- cpu_reset  out  1  active-high reset to the MIPS core.
- load_busy  out  1  high in every state except RUN and ERR.
- load_done  out  1  one-cycle pulse when a load completes.
- load_err  out  1  sticky overflow flag; cleared by load_start or reset.

Behaviour:
- States: HDR0, HDR1, DATA, WRITE, ZERO (optional), DONE, RUN, ERR.
- Reset (async, reset_n low):
  - state=HDR0, ptr=0, cnt=0, byte_idx=0.
  - cpu_reset=1, imem_we=0, imem_wd=0, load_done=0, load_err=0.
  - rx_ready therefore reads 1 right after reset; the system boots into a load.
- rx_ready: 1 in HDR0, HDR1 and DATA only; 0 in all other states. All outputs except imem_a are registered or decoded from state.
- HDR0: on a transfer, cnt[15:8]=byte, go to HDR1.
- HDR1: on a transfer, cnt[7:0]=byte.
  - If {cnt_hi,byte} > DEPTH: set load_err, go to ERR.
  - Else if it is 0: go to ZERO when zero-fill is compiled in, otherwise DONE.
  - Else go to DATA.
- DATA:
  - Each transfer shifts the byte into the word register, MSB first; byte_idx increments.
  - On the 4th byte (byte_idx==3), go to WRITE and wrap byte_idx to 0.
- WRITE (exactly one cycle):
  - imem_we=1, imem_a=ptr, imem_wd=assembled word.
  - Next cycle ptr increments. If ptr+1==cnt, go to ZERO or DONE; else return to DATA.
  - Minimum throughput is 5 cycles/word.
- DONE (one cycle): load_done=1, cpu_reset stays 1. Next cycle: state=RUN, cpu_reset=0.
- RUN: imem_a=cpu_addr (combinational mux), imem_we=0. load_start asserts cpu_reset=1 on the next edge and enters HDR0 with ptr=0.
- ERR: cpu_reset=1, rx_ready=0. load_start clears load_err and enters HDR0.
- load_start in HDR0..DONE is ignored.
- rx_valid without rx_ready: the byte is not consumed; the source must hold it.
- Reset mid-load: abort immediately. Words already written stay in imem; the partial image is not erased.
- ptr is ADDR_W+1 bits wide so a count of DEPTH compares without wrap. imem_a uses ptr[ADDR_W-1:0].

Optional Feature:
- Macro: IMEM_LOADER_ZERO_FILL_EN.
- Defined:
  - After the last data word, state ZERO writes 0 to every address from ptr to DEPTH-1, one word per cycle with imem_we=1, then goes to DONE.
  - A count of 0 zero-fills the entire memory.
  - DEPTH-cnt extra cycles.
- Undefined: ZERO does not exist; old contents above cnt remain.

Decomposition:
- Shared package mips_mem_pkg:
  - IMEM_ADDR_W=11, IMEM_DEPTH=1024, IMEM_WORD_W=32.
  - Loader state enum typedef.
- One natural sub-module: imem_loader_word_asm (byte shift register, byte_idx counter, word-complete pulse). The FSM and port mux stay in the top module.

Test Plan:
- Reset release, stream 00 02 | 20 08 00 05 | AC 08 00 3C:
  - Writes 0x20080005 @0 and 0xAC08003C @1, each with a single-cycle imem_we.
  - load_done pulses once; cpu_reset falls the cycle after; imem_a then follows cpu_addr=0x012.
- rx_valid toggled randomly 50% during the same image: identical writes, no dropped or duplicated bytes, rx_ready=0 during WRITE.
- Header 04 01 (1025 > DEPTH): load_err=1, state ERR, cpu_reset=1, no imem_we. Then load_start: load_err=0, a new header is accepted.
- In RUN, load_start then header 00 01, 12 34 56 78: cpu_reset reasserts next edge, 0x12345678 is written @0, CPU is released. A load_start issued mid-stream is ignored.
- reset_n pulsed low after 2 of 3 words: outputs return to reset values asynchronously, rx_ready=1, ptr=0. Words @0 and @1 are retained.
- With IMEM_LOADER_ZERO_FILL_EN and header 00 01 plus one word: 1023 zero writes @1..@1023, then load_done. Header 00 00 gives 1024 zero writes.
